instr_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read port; sits between the PC/branch logic and the synchronous instruction memory.
- Generates word addresses and read enables.
- Tracks the memory's fixed 1-cycle read latency.
- Presents fetched instructions to decode over a valid/ready handshake.
- Supports zero-bubble redirects (branches/jumps) and traps misaligned or out-of-range fetch addresses.

---
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 tb/tb_instr_fetch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: drives a 1-cycle-latency synchronous instruction
// memory and hands fetched words to decode over valid/ready, with zero-bubble redirects.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DEPTH    = 512,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic              fetch_err,
    output logic [31:0]       fetch_count
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_sel;
    logic [31:0] word_idx;
    logic        pc_bad;
    logic        can_go;
    logic        accept;
    logic        issue;

    assign pc_sel   = redirect_valid ? redirect_pc : fetch_pc_q;
    assign word_idx = {2'b00, pc_sel[31:2]};
    assign pc_bad   = (pc_sel[1:0] != 2'b00) || (word_idx >= DEPTH);
    // The response slot frees up when drained, consumed this cycle, or killed by a redirect.
    assign can_go   = !resp_valid_q || out_ready || redirect_valid;
    assign accept   = resp_valid_q && !redirect_valid && out_ready;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        resp_valid_d  = resp_valid_q;
        fetch_err_d   = fetch_err_q;
        issue         = 1'b0;
        fetch_count_d = fetch_count_q + {31'b0, accept};
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (can_go) begin
                    if (!pc_bad) begin
                        issue        = 1'b1;
                        fetch_pc_d   = pc_sel + 32'd4;
                        resp_pc_d    = pc_sel;
                        resp_valid_d = 1'b1;
                    end else begin
                        fetch_err_d  = 1'b1;
                        resp_valid_d = 1'b0;
                        state_d      = S_ERR;
                    end
                end
            end
            S_ERR: begin
                if (redirect_valid && !pc_bad) begin
                    issue        = 1'b1;
                    fetch_pc_d   = pc_sel + 32'd4;
                    resp_pc_d    = pc_sel;
                    resp_valid_d = 1'b1;
                    state_d      = S_RUN;
                end else if (accept || redirect_valid) begin
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= 32'd0;
            resp_valid_q  <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            resp_valid_q  <= resp_valid_d;
            fetch_err_q   <= fetch_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_sel[ADDR_W+1:2];
    assign imem_en     = issue;
    assign out_valid   = resp_valid_q && !redirect_valid;
    assign out_pc      = resp_pc_q;
    assign out_instr   = imem_rdata;
    assign fetch_err   = fetch_err_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed per-cycle vector bench for instr_fetch_unit with a synchronous memory model
// holding imem[i] = 32'h1000_0000 + i.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [8:0]  imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_err;
    logic [31:0] fetch_count;

    int total;
    int bad;

    logic [31:0] mem [512];

    instr_fetch_unit #(.ADDR_W(9), .DEPTH(512), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_err      (fetch_err),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    typedef struct packed {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        val;
        logic [31:0] pc;
        logic        en;
        logic [8:0]  addr;
        logic        err;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(logic rv, logic [31:0] rpc, logic rdy, logic val, logic [31:0] pc,
                                logic en, logic [8:0] addr, logic err, logic [31:0] cnt);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.val = val; v.pc = pc;
        v.en = en; v.addr = addr; v.err = err; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, check, then move to the next falling edge.
    task automatic apply(input vec_t v, input string tag);
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        out_ready      = v.rdy;
        #2;
        chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, v.val});
        if (v.val) begin
            chk({tag, ".out_pc"}, out_pc, v.pc);
            chk({tag, ".out_instr"}, out_instr, 32'h1000_0000 + {2'b00, v.pc[31:2]});
        end
        chk({tag, ".imem_en"}, {31'b0, imem_en}, {31'b0, v.en});
        if (v.en) chk({tag, ".imem_addr"}, {23'b0, imem_addr}, {23'b0, v.addr});
        chk({tag, ".fetch_err"}, {31'b0, fetch_err}, {31'b0, v.err});
        chk({tag, ".fetch_count"}, fetch_count, v.cnt);
        @(negedge clk);
    endtask

    vec_t tbl [23];
    vec_t hnd [7];

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + i;

        //             rv  rpc           rdy val pc            en addr     err cnt
        tbl[0]  = mk(0, 32'h0,       1, 0, 32'h0,       0, 9'd0,   0, 0);  // BOOT
        tbl[1]  = mk(0, 32'h0,       1, 0, 32'h0,       1, 9'd0,   0, 0);
        tbl[2]  = mk(0, 32'h0,       1, 1, 32'h0,       1, 9'd1,   0, 0);
        tbl[3]  = mk(0, 32'h0,       1, 1, 32'h4,       1, 9'd2,   0, 1);
        tbl[4]  = mk(0, 32'h0,       0, 1, 32'h8,       0, 9'd0,   0, 2);  // stall x3
        tbl[5]  = mk(0, 32'h0,       0, 1, 32'h8,       0, 9'd0,   0, 2);
        tbl[6]  = mk(0, 32'h0,       0, 1, 32'h8,       0, 9'd0,   0, 2);
        tbl[7]  = mk(0, 32'h0,       1, 1, 32'h8,       1, 9'd3,   0, 2);
        tbl[8]  = mk(0, 32'h0,       1, 1, 32'hC,       1, 9'd4,   0, 3);
        tbl[9]  = mk(1, 32'h40,      1, 0, 32'h0,       1, 9'd16,  0, 4);  // kills 0x10
        tbl[10] = mk(0, 32'h0,       1, 1, 32'h40,      1, 9'd17,  0, 4);
        tbl[11] = mk(0, 32'h0,       1, 1, 32'h44,      1, 9'd18,  0, 5);
        tbl[12] = mk(1, 32'h7F0,     1, 0, 32'h0,       1, 9'd508, 0, 6);
        tbl[13] = mk(0, 32'h0,       1, 1, 32'h7F0,     1, 9'd509, 0, 6);
        tbl[14] = mk(0, 32'h0,       1, 1, 32'h7F4,     1, 9'd510, 0, 7);
        tbl[15] = mk(0, 32'h0,       1, 1, 32'h7F8,     1, 9'd511, 0, 8);
        tbl[16] = mk(0, 32'h0,       1, 1, 32'h7FC,     0, 9'd0,   0, 9);  // next pc 0x800
        tbl[17] = mk(0, 32'h0,       1, 0, 32'h0,       0, 9'd0,   1, 10);
        tbl[18] = mk(1, 32'h42,      1, 0, 32'h0,       0, 9'd0,   1, 10);
        tbl[19] = mk(0, 32'h0,       1, 0, 32'h0,       0, 9'd0,   1, 10);
        tbl[20] = mk(1, 32'h80,      1, 0, 32'h0,       1, 9'd32,  1, 10);
        tbl[21] = mk(0, 32'h0,       1, 1, 32'h80,      1, 9'd33,  1, 10);
        tbl[22] = mk(0, 32'h0,       1, 1, 32'h84,      1, 9'd34,  1, 11);

        hnd[0]  = mk(0, 32'h0,       1, 0, 32'h0,       0, 9'd0,   0, 0);  // BOOT
        hnd[1]  = mk(0, 32'h0,       1, 0, 32'h0,       1, 9'd0,   0, 0);
        hnd[2]  = mk(1, 32'h42,      1, 0, 32'h0,       0, 9'd0,   0, 0);  // misaligned
        hnd[3]  = mk(0, 32'h0,       1, 0, 32'h0,       0, 9'd0,   1, 0);
        hnd[4]  = mk(1, 32'h80,      1, 0, 32'h0,       1, 9'd32,  1, 0);
        hnd[5]  = mk(0, 32'h0,       1, 1, 32'h80,      1, 9'd33,  1, 0);
        hnd[6]  = mk(0, 32'h0,       1, 1, 32'h84,      1, 9'd34,  1, 1);

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.imem_en", {31'b0, imem_en}, 32'd0);
        chk("rst.fetch_err", {31'b0, fetch_err}, 32'd0);
        chk("rst.fetch_count", fetch_count, 32'd0);

        rst_n = 1'b1;
        for (int i = 0; i < 23; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Asynchronous reset landing between edges while an instruction is presented.
        #3;
        chk("pre_rst.out_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst.imem_en", {31'b0, imem_en}, 32'd0);
        chk("mid_rst.fetch_count", fetch_count, 32'd0);
        chk("mid_rst.fetch_err", {31'b0, fetch_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) apply(hnd[i], $sformatf("hnd%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
